// File: rtl/wt_cache_pkg.sv
// Shared definitions for the write-through cache memory-request arbiter.
//   WtArbMaxClients  : largest supported number of cache clients
//   arb_state_e      : request FSM state encoding
//   wt_arb_tid_width : memory-side transaction ID width, i.e. the client ID
//                      width plus a client-index field of at least one bit
package wt_cache_pkg;

    localparam int WtArbMaxClients = 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_REQ  = 1'b1
    } arb_state_e;

    // The index field keeps one bit even for a single client so the
    // memory-side ID layout does not change shape with the client count.
    function automatic int wt_arb_tid_width(input int num_clients, input int tid_width);
        int idx_w;
        idx_w = (num_clients > 1) ? $clog2(num_clients) : 1;
        return tid_width + idx_w;
    endfunction

endpackage

// File: rtl/wt_rr_pick.sv
// Combinational round-robin picker.
//   eligible : per-client eligibility
//   ptr      : client with highest priority this cycle
//   onehot   : one-hot select of the chosen client
//   idx      : binary index of the chosen client
//   valid    : some client was chosen
module wt_rr_pick #(
    parameter int NumClients = 2,
    parameter int IdxWidth   = (NumClients > 1) ? $clog2(NumClients) : 1
) (
    input  logic [NumClients-1:0] eligible,
    input  logic [IdxWidth-1:0]   ptr,
    output logic [NumClients-1:0] onehot,
    output logic [IdxWidth-1:0]   idx,
    output logic                  valid
);

    always_comb begin
        int j;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        j      = 0;
        // Scan from the pointer upward, wrapping; first eligible client wins.
        for (int off = 0; off < NumClients; off++) begin
            j = (int'(ptr) + off) % NumClients;
            if (!valid && eligible[j]) begin
                valid     = 1'b1;
                onehot[j] = 1'b1;
                idx       = IdxWidth'(j);
            end
        end
    end

endmodule

// File: rtl/wt_mem_req_arbiter.sv
// N-client arbiter between write-through L1 caches and one memory adapter.
// Round-robin grant, memory-side ID = {client index, client tid}, per-client
// limit on response-expecting transactions in flight, registered return path.
//
// State    | meaning
// ---------+-----------------------------------------------------------
// ARB_IDLE | no request held; may grant an eligible client if !stall_i
// ARB_REQ  | latched request presented on mem_req_o until mem_ack_i
//
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   stall_i           : blocks new grants only
//   busy_o, err_o     : activity indication, sticky return-path error
//   cl_*              : per-client request inputs, ack, broadcast return
//   mem_*             : registered request to adapter, return from adapter
module wt_mem_req_arbiter
    import wt_cache_pkg::*;
#(
    parameter int NumClients     = 2,
    parameter int TxIdWidth      = 2,
    parameter int ReqWidth       = 128,
    parameter int RtrnWidth      = 128,
    parameter int MaxOutstanding = 4,
    parameter int MemTidWidth    = wt_arb_tid_width(NumClients, TxIdWidth)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            stall_i,
    output logic                            busy_o,
    output logic                            err_o,
    input  logic [NumClients-1:0]           cl_req_i,
    output logic [NumClients-1:0]           cl_ack_o,
    input  logic [NumClients*ReqWidth-1:0]  cl_data_i,
    input  logic [NumClients*TxIdWidth-1:0] cl_tid_i,
    input  logic [NumClients-1:0]           cl_rsp_exp_i,
    output logic [NumClients-1:0]           cl_rtrn_vld_o,
    output logic [RtrnWidth-1:0]            cl_rtrn_data_o,
    output logic [TxIdWidth-1:0]            cl_rtrn_tid_o,
    output logic                            mem_req_o,
    input  logic                            mem_ack_i,
    output logic [ReqWidth-1:0]             mem_data_o,
    output logic [MemTidWidth-1:0]          mem_tid_o,
    output logic                            mem_rsp_exp_o,
    input  logic                            mem_rtrn_vld_i,
    input  logic [RtrnWidth-1:0]            mem_rtrn_data_i,
    input  logic [MemTidWidth-1:0]          mem_rtrn_tid_i
);

    localparam int IdxWidth = MemTidWidth - TxIdWidth;
    localparam int CntWidth = $clog2(MaxOutstanding + 1);

    arb_state_e              state_q;
    logic                    mem_req_q;
    logic [ReqWidth-1:0]     mem_data_q;
    logic [MemTidWidth-1:0]  mem_tid_q;
    logic                    rsp_exp_q;
    logic [NumClients-1:0]   gnt_oh_q;
    logic [IdxWidth-1:0]     gnt_idx_q;
    logic [IdxWidth-1:0]     rr_ptr_q;
    logic [CntWidth-1:0]     cnt_q [NumClients];
    logic [NumClients-1:0]   rtrn_vld_q;
    logic [RtrnWidth-1:0]    rtrn_data_q;
    logic [TxIdWidth-1:0]    rtrn_tid_q;
    logic                    err_q;

    logic [NumClients-1:0]   elig;
    logic [NumClients-1:0]   pick_oh;
    logic [IdxWidth-1:0]     pick_idx;
    logic                    pick_vld;
    logic                    ack_hs;
    logic [IdxWidth-1:0]     rtrn_idx;
    logic                    rtrn_in_range;
    logic [NumClients-1:0]   rtrn_oh;
    logic [NumClients-1:0]   cnt_inc;
    logic [NumClients-1:0]   cnt_dec;
    logic                    rtrn_cnt_zero;
    logic                    cnt_any;

    // Reset suppresses the ack so a dropped handshake is never acknowledged.
    assign ack_hs        = (state_q == ARB_REQ) && mem_ack_i && !rst_i;
    assign rtrn_idx      = mem_rtrn_tid_i[MemTidWidth-1:TxIdWidth];
    assign rtrn_in_range = int'(rtrn_idx) < NumClients;

    always_comb begin
        elig          = '0;
        rtrn_oh       = '0;
        cnt_inc       = '0;
        cnt_dec       = '0;
        rtrn_cnt_zero = 1'b0;
        cnt_any       = 1'b0;
        for (int i = 0; i < NumClients; i++) begin
            elig[i]    = cl_req_i[i] &&
                         !(cl_rsp_exp_i[i] && cnt_q[i] == CntWidth'(MaxOutstanding));
            rtrn_oh[i] = mem_rtrn_vld_i && (rtrn_idx == IdxWidth'(i));
            cnt_inc[i] = ack_hs && rsp_exp_q && gnt_oh_q[i];
            cnt_dec[i] = rtrn_oh[i] && (cnt_q[i] != '0);
            if (rtrn_oh[i] && cnt_q[i] == '0) rtrn_cnt_zero = 1'b1;
            if (cnt_q[i] != '0) cnt_any = 1'b1;
        end
    end

    wt_rr_pick #(
        .NumClients (NumClients),
        .IdxWidth   (IdxWidth)
    ) u_rr_pick (
        .eligible (elig),
        .ptr      (rr_ptr_q),
        .onehot   (pick_oh),
        .idx      (pick_idx),
        .valid    (pick_vld)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_data_q  <= '0;
            mem_tid_q   <= '0;
            rsp_exp_q   <= 1'b0;
            gnt_oh_q    <= '0;
            gnt_idx_q   <= '0;
            rr_ptr_q    <= '0;
            rtrn_vld_q  <= '0;
            rtrn_data_q <= '0;
            rtrn_tid_q  <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NumClients; i++) cnt_q[i] <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (!stall_i && pick_vld) begin
                        state_q    <= ARB_REQ;
                        mem_req_q  <= 1'b1;
                        mem_data_q <= cl_data_i[pick_idx*ReqWidth +: ReqWidth];
                        mem_tid_q  <= {pick_idx, cl_tid_i[pick_idx*TxIdWidth +: TxIdWidth]};
                        rsp_exp_q  <= cl_rsp_exp_i[pick_idx];
                        gnt_oh_q   <= pick_oh;
                        gnt_idx_q  <= pick_idx;
                    end
                end
                ARB_REQ: begin
                    if (mem_ack_i) begin
                        state_q   <= ARB_IDLE;
                        mem_req_q <= 1'b0;
                        rr_ptr_q  <= (int'(gnt_idx_q) == NumClients - 1) ? '0
                                                                        : gnt_idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= ARB_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase

            // An ack and a legal return for the same client cancel out.
            for (int i = 0; i < NumClients; i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
                else if (cnt_dec[i] && !cnt_inc[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
            end

            rtrn_vld_q <= rtrn_oh;
            if (mem_rtrn_vld_i && rtrn_in_range) begin
                rtrn_data_q <= mem_rtrn_data_i;
                rtrn_tid_q  <= mem_rtrn_tid_i[TxIdWidth-1:0];
            end
            if (mem_rtrn_vld_i && (!rtrn_in_range || rtrn_cnt_zero)) err_q <= 1'b1;
        end
    end

    assign cl_ack_o       = ack_hs ? gnt_oh_q : '0;
    assign mem_req_o      = mem_req_q;
    assign mem_data_o     = mem_data_q;
    assign mem_tid_o      = mem_tid_q;
    assign mem_rsp_exp_o  = rsp_exp_q;
    assign cl_rtrn_vld_o  = rtrn_vld_q;
    assign cl_rtrn_data_o = rtrn_data_q;
    assign cl_rtrn_tid_o  = rtrn_tid_q;
    assign err_o          = err_q;
    assign busy_o         = mem_req_q | (|cl_req_i) | cnt_any;

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
module tb_wt_mem_req_arbiter;

    localparam int N   = 3;
    localparam int TW  = 2;
    localparam int RW  = 32;
    localparam int RTW = 32;
    localparam int MO  = 2;
    localparam int MTW = 4;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           stall_i;
    logic           busy_o;
    logic           err_o;
    logic [N-1:0]   cl_req_i;
    logic [N-1:0]   cl_ack_o;
    logic [N*RW-1:0] cl_data_i;
    logic [N*TW-1:0] cl_tid_i;
    logic [N-1:0]   cl_rsp_exp_i;
    logic [N-1:0]   cl_rtrn_vld_o;
    logic [RTW-1:0] cl_rtrn_data_o;
    logic [TW-1:0]  cl_rtrn_tid_o;
    logic           mem_req_o;
    logic           mem_ack_i;
    logic [RW-1:0]  mem_data_o;
    logic [MTW-1:0] mem_tid_o;
    logic           mem_rsp_exp_o;
    logic           mem_rtrn_vld_i;
    logic [RTW-1:0] mem_rtrn_data_i;
    logic [MTW-1:0] mem_rtrn_tid_i;

    wt_mem_req_arbiter #(
        .NumClients(N), .TxIdWidth(TW), .ReqWidth(RW), .RtrnWidth(RTW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .busy_o(busy_o), .err_o(err_o),
        .cl_req_i(cl_req_i), .cl_ack_o(cl_ack_o), .cl_data_i(cl_data_i), .cl_tid_i(cl_tid_i),
        .cl_rsp_exp_i(cl_rsp_exp_i), .cl_rtrn_vld_o(cl_rtrn_vld_o),
        .cl_rtrn_data_o(cl_rtrn_data_o), .cl_rtrn_tid_o(cl_rtrn_tid_o),
        .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i), .mem_data_o(mem_data_o),
        .mem_tid_o(mem_tid_o), .mem_rsp_exp_o(mem_rsp_exp_o),
        .mem_rtrn_vld_i(mem_rtrn_vld_i), .mem_rtrn_data_i(mem_rtrn_data_i),
        .mem_rtrn_tid_i(mem_rtrn_tid_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Reference model: outstanding counts, round-robin pointer, client payloads.
    int           m_cnt [N];
    int           m_ptr;
    logic [RW-1:0] m_data [N];
    logic [TW-1:0] m_tid  [N];

    function automatic int model_pick(input logic [N-1:0] req, input logic [N-1:0] rsp);
        for (int off = 0; off < N; off++) begin
            int j;
            j = (m_ptr + off) % N;
            if (req[j] && !(rsp[j] && m_cnt[j] == MO)) return j;
        end
        return -1;
    endfunction

    function automatic void model_ack(input int c, input bit rsp);
        m_ptr = (c + 1) % N;
        if (rsp) m_cnt[c] = m_cnt[c] + 1;
    endfunction

    function automatic void model_reset();
        m_ptr = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endfunction

    task automatic set_client(input int c, input bit req, input bit rsp);
        m_data[c] = $urandom;
        m_tid[c]  = TW'($urandom);
        cl_req_i[c]     = req;
        cl_rsp_exp_i[c] = rsp;
        cl_data_i[c*RW +: RW] = m_data[c];
        cl_tid_i[c*TW +: TW]  = m_tid[c];
    endtask

    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (mem_req_o === 1'b1) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1; stall_i = 1'b0; cl_req_i = '0; cl_data_i = '0; cl_tid_i = '0;
        cl_rsp_exp_i = '0; mem_ack_i = 1'b0; mem_rtrn_vld_i = 1'b0;
        mem_rtrn_data_i = '0; mem_rtrn_tid_i = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        bit got;
        do_reset();
        total++;
        if ({cl_ack_o, cl_rtrn_vld_o, cl_rtrn_data_o, cl_rtrn_tid_o, mem_req_o, mem_data_o,
             mem_tid_o, mem_rsp_exp_o, busy_o, err_o} !== '0) begin
            bad++; $display("FAIL reset_outputs: got nonzero outputs after reset, required all 0");
        end
        @(negedge clk_i);
        total++;
        if ({mem_req_o, busy_o, err_o, cl_ack_o} !== '0) begin
            bad++; $display("FAIL idle_outputs: req=%b busy=%b err=%b ack=%b, required 0",
                            mem_req_o, busy_o, err_o, cl_ack_o);
        end
        set_client(0, 1'b1, 1'b1);
        wait_req(got);
        total++;
        if (!got) begin bad++; $display("FAIL reset_req_timeout: mem_req_o never rose"); end
        rst_i = 1'b1; mem_ack_i = 1'b1; cl_req_i = '0;
        #1;
        total++;
        if (cl_ack_o !== 3'b000) begin
            bad++; $display("FAIL reset_no_ack: cl_ack_o=%b required 000", cl_ack_o);
        end
        @(negedge clk_i);
        total++;
        if (mem_req_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL reset_drop_req: mem_req_o=%b busy_o=%b required 0 0", mem_req_o, busy_o);
        end
        rst_i = 1'b0; mem_ack_i = 1'b0;
        model_reset();
    endtask

    task automatic test_fairness();
        bit got;
        int last;
        last = 0;
        for (int c = 0; c < N; c++) set_client(c, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            int e;
            e = k % N;
            wait_req(got);
            total++;
            if (!got) begin bad++; $display("FAIL fair_timeout k=%0d", k); end
            total++;
            if (mem_tid_o !== {2'(e), m_tid[e]} || mem_data_o !== m_data[e] || mem_rsp_exp_o !== 1'b0) begin
                bad++; $display("FAIL fair_grant k=%0d: tid=%h data=%h rsp=%b required tid=%h data=%h rsp=0",
                                k, mem_tid_o, mem_data_o, mem_rsp_exp_o, {2'(e), m_tid[e]}, m_data[e]);
            end
            mem_ack_i = 1'b1;
            #1;
            total++;
            if (cl_ack_o !== 3'(1 << e)) begin
                bad++; $display("FAIL fair_ack k=%0d: cl_ack_o=%b required %b", k, cl_ack_o, 3'(1 << e));
            end
            if (k > 0) begin
                total++;
                if (cyc - last != 2) begin
                    bad++; $display("FAIL fair_rate k=%0d: ack spacing %0d required 2", k, cyc - last);
                end
            end
            last = cyc;
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            model_ack(e, 1'b0);
            if (k == 5) cl_req_i = '0;
            else set_client(e, 1'b1, 1'b0);
        end
        @(negedge clk_i);
        total++;
        if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
            bad++; $display("FAIL posted_cnt: busy_o=%b mem_req_o=%b required 0 0", busy_o, mem_req_o);
        end
    endtask

    task automatic test_limit();
        bit got;
        bit seen;
        logic [RTW-1:0] rd;
        logic [TW-1:0]  rt;
        set_client(1, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            wait_req(got);
            total++;
            if (!got || mem_tid_o !== {2'd1, m_tid[1]} || mem_rsp_exp_o !== 1'b1) begin
                bad++; $display("FAIL limit_grant k=%0d: got=%b tid=%h rsp=%b required tid=%h rsp=1",
                                k, got, mem_tid_o, mem_rsp_exp_o, {2'd1, m_tid[1]});
            end
            mem_ack_i = 1'b1;
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            model_ack(1, 1'b1);
            set_client(1, 1'b1, 1'b1);
        end
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            if (mem_req_o === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0 || busy_o !== 1'b1) begin
            bad++; $display("FAIL limit_block: granted=%b busy_o=%b required 0 1", seen, busy_o);
        end
        rd = $urandom;
        mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 4'b0111; mem_rtrn_data_i = rd;
        @(negedge clk_i);
        mem_rtrn_vld_i = 1'b0;
        m_cnt[1]--;
        total++;
        if (cl_rtrn_vld_o !== 3'b010 || cl_rtrn_tid_o !== 2'b11 || cl_rtrn_data_o !== rd) begin
            bad++; $display("FAIL limit_rtrn: vld=%b tid=%b data=%h required 010 11 %h",
                            cl_rtrn_vld_o, cl_rtrn_tid_o, cl_rtrn_data_o, rd);
        end
        wait_req(got);
        total++;
        if (!got || mem_tid_o !== {2'd1, m_tid[1]}) begin
            bad++; $display("FAIL limit_regrant: got=%b tid=%h required %h", got, mem_tid_o, {2'd1, m_tid[1]});
        end
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i = 1'b0; cl_req_i = '0;
        model_ack(1, 1'b1);
        while (m_cnt[1] > 0) begin
            rt = TW'($urandom);
            mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = {2'd1, rt};
            @(negedge clk_i);
            mem_rtrn_vld_i = 1'b0;
            m_cnt[1]--;
            total++;
            if (cl_rtrn_vld_o !== 3'b010 || cl_rtrn_tid_o !== rt) begin
                bad++; $display("FAIL limit_drain: vld=%b tid=%b required 010 %b", cl_rtrn_vld_o, cl_rtrn_tid_o, rt);
            end
        end
        total++;
        if (err_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL limit_idle: err_o=%b busy_o=%b required 0 0", err_o, busy_o);
        end
    endtask

    task automatic test_simultaneous();
        bit got;
        set_client(0, 1'b1, 1'b1);
        wait_req(got);
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        model_ack(0, 1'b1);
        set_client(0, 1'b1, 1'b1);
        wait_req(got);
        total++;
        if (!got || mem_tid_o !== {2'd0, m_tid[0]}) begin
            bad++; $display("FAIL simul_grant: got=%b tid=%h required %h", got, mem_tid_o, {2'd0, m_tid[0]});
        end
        mem_ack_i = 1'b1; mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = {2'd0, 2'b10};
        #1;
        total++;
        if (cl_ack_o !== 3'b001) begin
            bad++; $display("FAIL simul_ack: cl_ack_o=%b required 001", cl_ack_o);
        end
        @(negedge clk_i);
        mem_ack_i = 1'b0; mem_rtrn_vld_i = 1'b0; cl_req_i = '0;
        total++;
        if (cl_rtrn_vld_o !== 3'b001 || err_o !== 1'b0) begin
            bad++; $display("FAIL simul_rtrn: vld=%b err=%b required 001 0", cl_rtrn_vld_o, err_o);
        end
        mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = {2'd0, 2'b01};
        @(negedge clk_i);
        mem_rtrn_vld_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (err_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL simul_cnt: err_o=%b busy_o=%b required 0 0 (count must have been 1)",
                            err_o, busy_o);
        end
    endtask

    task automatic test_errors();
        logic [RTW-1:0] rd;
        mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 4'b1101; mem_rtrn_data_i = $urandom;
        @(negedge clk_i);
        mem_rtrn_vld_i = 1'b0;
        total++;
        if (cl_rtrn_vld_o !== 3'b000 || err_o !== 1'b1) begin
            bad++; $display("FAIL err_range: vld=%b err=%b required 000 1", cl_rtrn_vld_o, err_o);
        end
        repeat (3) @(negedge clk_i);
        total++;
        if (err_o !== 1'b1) begin bad++; $display("FAIL err_sticky: err_o=%b required 1", err_o); end
        rd = $urandom;
        mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 4'b1010; mem_rtrn_data_i = rd;
        @(negedge clk_i);
        mem_rtrn_vld_i = 1'b0;
        total++;
        if (cl_rtrn_vld_o !== 3'b100 || cl_rtrn_tid_o !== 2'b10 || cl_rtrn_data_o !== rd || err_o !== 1'b1) begin
            bad++; $display("FAIL err_zero_cnt: vld=%b tid=%b data=%h err=%b required 100 10 %h 1",
                            cl_rtrn_vld_o, cl_rtrn_tid_o, cl_rtrn_data_o, err_o, rd);
        end
        @(negedge clk_i);
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL err_saturate: busy_o=%b required 0", busy_o); end
    endtask

    task automatic test_stall();
        bit seen;
        do_reset();
        total++;
        if (err_o !== 1'b0) begin bad++; $display("FAIL err_clear: err_o=%b required 0", err_o); end
        stall_i = 1'b1;
        set_client(2, 1'b1, 1'b0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            if (mem_req_o === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0 || busy_o !== 1'b1) begin
            bad++; $display("FAIL stall_block: granted=%b busy_o=%b required 0 1", seen, busy_o);
        end
        stall_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (mem_req_o !== 1'b1 || mem_tid_o !== {2'd2, m_tid[2]}) begin
            bad++; $display("FAIL stall_release: req=%b tid=%h required 1 %h", mem_req_o, mem_tid_o, {2'd2, m_tid[2]});
        end
        stall_i = 1'b1; mem_ack_i = 1'b1;
        #1;
        total++;
        if (cl_ack_o !== 3'b100) begin
            bad++; $display("FAIL stall_in_req_ack: cl_ack_o=%b required 100", cl_ack_o);
        end
        @(negedge clk_i);
        mem_ack_i = 1'b0; cl_req_i = '0; stall_i = 1'b0;
        model_ack(2, 1'b0);
        @(negedge clk_i);
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL stall_posted: busy_o=%b required 0", busy_o); end
    endtask

    task automatic test_random();
        bit got;
        for (int it = 0; it < 30; it++) begin
            logic [N-1:0] req;
            logic [N-1:0] rsp;
            int e;
            if ($urandom_range(0, 1) == 1 && (m_cnt[0] + m_cnt[1] + m_cnt[2]) > 0) begin
                int c;
                logic [TW-1:0] rt;
                c = $urandom_range(0, N - 1);
                while (m_cnt[c] == 0) c = (c + 1) % N;
                rt = TW'($urandom);
                mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = {2'(c), rt}; mem_rtrn_data_i = $urandom;
                @(negedge clk_i);
                mem_rtrn_vld_i = 1'b0;
                m_cnt[c]--;
                total++;
                if (cl_rtrn_vld_o !== 3'(1 << c) || cl_rtrn_tid_o !== rt) begin
                    bad++; $display("FAIL rand_rtrn it=%0d: vld=%b tid=%b required %b %b",
                                    it, cl_rtrn_vld_o, cl_rtrn_tid_o, 3'(1 << c), rt);
                end
            end
            req = 3'($urandom_range(1, 7));
            rsp = 3'($urandom);
            for (int c = 0; c < N; c++) set_client(c, req[c], rsp[c]);
            e = model_pick(req, rsp);
            if (e < 0) begin
                @(negedge clk_i);
                @(negedge clk_i);
                total++;
                if (mem_req_o !== 1'b0) begin
                    bad++; $display("FAIL rand_block it=%0d: mem_req_o=%b required 0", it, mem_req_o);
                end
                cl_req_i = '0;
            end else begin
                wait_req(got);
                total++;
                if (!got || mem_tid_o !== {2'(e), m_tid[e]} || mem_data_o !== m_data[e] ||
                    mem_rsp_exp_o !== rsp[e]) begin
                    bad++; $display("FAIL rand_grant it=%0d: got=%b tid=%h data=%h rsp=%b required tid=%h data=%h rsp=%b",
                                    it, got, mem_tid_o, mem_data_o, mem_rsp_exp_o, {2'(e), m_tid[e]}, m_data[e], rsp[e]);
                end
                mem_ack_i = 1'b1;
                #1;
                total++;
                if (cl_ack_o !== 3'(1 << e)) begin
                    bad++; $display("FAIL rand_ack it=%0d: cl_ack_o=%b required %b", it, cl_ack_o, 3'(1 << e));
                end
                @(negedge clk_i);
                mem_ack_i = 1'b0; cl_req_i = '0;
                model_ack(e, rsp[e]);
            end
        end
        for (int c = 0; c < N; c++) begin
            while (m_cnt[c] > 0) begin
                mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = {2'(c), 2'b00};
                @(negedge clk_i);
                mem_rtrn_vld_i = 1'b0;
                m_cnt[c]--;
            end
        end
        @(negedge clk_i);
        total++;
        if (busy_o !== 1'b0 || err_o !== 1'b0) begin
            bad++; $display("FAIL rand_drain: busy_o=%b err_o=%b required 0 0", busy_o, err_o);
        end
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; cl_req_i = '0; cl_data_i = '0; cl_tid_i = '0;
        cl_rsp_exp_i = '0; mem_ack_i = 1'b0; mem_rtrn_vld_i = 1'b0;
        mem_rtrn_data_i = '0; mem_rtrn_tid_i = '0;
        model_reset();
        test_reset();
        test_fairness();
        test_limit();
        test_simultaneous();
        test_errors();
        test_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
